// File: rtl/dc_pkg.sv
// dc_pkg: shared default widths and log2 helper for the width-narrowing converter
package dc_pkg;

   localparam int DC_IN_W  = 32;
   localparam int DC_RATIO = 2;

   // Smallest r with 2**r >= v, evaluated at elaboration for lane-pointer widths
   function automatic int dc_log2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/dc_narrow.sv
// dc_narrow: splits one wide slave word into up to RATIO narrow master lanes, one lane per cycle
module dc_narrow
   import dc_pkg::*;
#(
   parameter int IN_W      = DC_IN_W,
   parameter int RATIO     = DC_RATIO,
   parameter bit LSB_FIRST = 1'b1,
   localparam int OUT_W    = IN_W / RATIO,
   localparam int LW       = dc_log2(RATIO)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  s_data_i,
   input  logic [LW-1:0]    s_lanes_i,
   input  logic             s_sof,
   input  logic             s_eof,
   input  logic             s_vld_i,
   output logic             s_rdy_o,
   output logic [OUT_W-1:0] m_data_o,
   output logic             m_sof,
   output logic             m_eof,
   output logic             m_vld_o,
   input  logic             m_rdy_i
);

   logic [IN_W-1:0]  data_q, data_d;
   logic             sof_q, sof_d, eof_q, eof_d, full_q, full_d;
   logic [LW-1:0]    last_q, last_d, ptr_q, ptr_d;
   logic             at_last, accept;
   logic [OUT_W-1:0] lane [RATIO];

   assign at_last = ptr_q == last_q;
   // A new word may enter only when the hold register is empty or its final lane leaves this cycle
   assign s_rdy_o = !full_q | (m_rdy_i & at_last);
   assign accept  = s_vld_i & s_rdy_o;

   // Lane g of the presentation order maps to a fixed slice of the held word
   for (genvar g = 0; g < RATIO; g++) begin : g_lane
      assign lane[g] = data_q[(LSB_FIRST ? g : RATIO - 1 - g) * OUT_W +: OUT_W];
   end

   assign m_vld_o  = full_q;
   assign m_data_o = lane[ptr_q];
   assign m_sof    = full_q & (ptr_q == '0) & sof_q;
   assign m_eof    = full_q & at_last & eof_q;

   // Next state: a load wins over the final-lane drain so consecutive words flow without a bubble
   always_comb begin
      data_d = data_q;
      sof_d  = sof_q;
      eof_d  = eof_q;
      last_d = last_q;
      ptr_d  = ptr_q;
      full_d = full_q;
      if (accept) begin
         data_d = s_data_i;
         sof_d  = s_sof;
         eof_d  = s_eof;
         last_d = s_lanes_i;
         ptr_d  = '0;
         full_d = 1'b1;
      end else if (full_q & m_rdy_i) begin
         ptr_d  = at_last ? ptr_q : ptr_q + 1'b1;
         full_d = !at_last;
      end
   end

   // State registers; reset drops any partially sent word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         sof_q  <= 1'b0;
         eof_q  <= 1'b0;
         last_q <= '0;
         ptr_q  <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         sof_q  <= sof_d;
         eof_q  <= eof_d;
         last_q <= last_d;
         ptr_q  <= ptr_d;
         full_q <= full_d;
      end
   end

endmodule
